// File: rtl/pipeline_stall_ctrl.sv
// Pipeline freeze/flush sequencer: merges hazard and branch flags with a
// data-memory wait-state FSM and keeps saturating stall/flush cycle counters.
module pipeline_stall_ctrl #(
  parameter int unsigned MEM_WAIT = 4,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hazard,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             perf_clr,
  output logic             freeze_if,
  output logic             freeze_id,
  output logic             freeze_exe,
  output logic             freeze_mem,
  output logic             flush_if_id,
  output logic             flush_id_exe,
  output logic             mem_wb_bubble,
  output logic             mem_ready,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

  localparam bit             HasWait  = (MEM_WAIT != 0);
  localparam logic [3:0]     WaitInit = HasWait ? 4'(MEM_WAIT - 1) : 4'd0;
  localparam logic [CNT_W-1:0] CntMax = '1;

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;

  logic mem_stall, mem_done, rule_flush, rule_haz, run;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (mem_req && HasWait) begin
          cnt_d   = WaitInit;
          state_d = (MEM_WAIT == 1) ? StDone : StWait;
        end
      end
      StWait: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = StDone;
      end
      // The finishing instruction leaves MEM here, so mem_req is not re-sampled.
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output logic
  always_comb begin
    run        = !rst;
    mem_stall  = ((state_q == StIdle) && mem_req && HasWait) || (state_q == StWait);
    mem_done   = (state_q == StDone) || ((state_q == StIdle) && mem_req && !HasWait);
    // Memory stall masks both flags; the frozen instructions re-present them later.
    rule_flush = !mem_stall && branch_taken;
    rule_haz   = !mem_stall && !branch_taken && hazard;

    freeze_if     = run && (mem_stall || rule_haz);
    freeze_id     = run && mem_stall;
    freeze_exe    = run && mem_stall;
    freeze_mem    = run && mem_stall;
    mem_wb_bubble = run && mem_stall;
    flush_if_id   = run && rule_flush;
    flush_id_exe  = run && (rule_flush || rule_haz);
    mem_ready     = run && mem_done;
    stall_cnt     = run ? stall_q : '0;
    flush_cnt     = run ? flush_q : '0;
  end

  // Saturating performance counters
  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (perf_clr) begin
      stall_d = '0;
      flush_d = '0;
    end else begin
      if ((mem_stall || rule_haz) && (stall_q != CntMax)) stall_d = stall_q + CNT_W'(1);
      if (rule_flush && (flush_q != CntMax)) flush_d = flush_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Scoreboard bench: two configurations (MEM_WAIT=4/CNT_W=16 and MEM_WAIT=0/CNT_W=2)
// share stimulus; a cycle-level reference model predicts every output.
module tb_pipeline_stall_ctrl;

  typedef struct packed {
    logic [7:0]  ctrl;
    logic [15:0] scnt;
    logic [15:0] fcnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1, hazard = 1'b0, branch_taken = 1'b0, mem_req = 1'b0, perf_clr = 1'b0;

  logic f_if0, f_id0, f_exe0, f_mem0, fl_ifid0, fl_idexe0, bub0, rdy0;
  logic [15:0] scnt0, fcnt0;
  logic f_if1, f_id1, f_exe1, f_mem1, fl_ifid1, fl_idexe1, bub1, rdy1;
  logic [1:0] scnt1, fcnt1;

  always #5 clk = ~clk;

  pipeline_stall_ctrl #(.MEM_WAIT(4), .CNT_W(16)) dut0 (
    .clk(clk), .rst(rst), .hazard(hazard), .branch_taken(branch_taken), .mem_req(mem_req),
    .perf_clr(perf_clr), .freeze_if(f_if0), .freeze_id(f_id0), .freeze_exe(f_exe0),
    .freeze_mem(f_mem0), .flush_if_id(fl_ifid0), .flush_id_exe(fl_idexe0),
    .mem_wb_bubble(bub0), .mem_ready(rdy0), .stall_cnt(scnt0), .flush_cnt(fcnt0)
  );

  pipeline_stall_ctrl #(.MEM_WAIT(0), .CNT_W(2)) dut1 (
    .clk(clk), .rst(rst), .hazard(hazard), .branch_taken(branch_taken), .mem_req(mem_req),
    .perf_clr(perf_clr), .freeze_if(f_if1), .freeze_id(f_id1), .freeze_exe(f_exe1),
    .freeze_mem(f_mem1), .flush_if_id(fl_ifid1), .flush_id_exe(fl_idexe1),
    .mem_wb_bubble(bub1), .mem_ready(rdy1), .stall_cnt(scnt1), .flush_cnt(fcnt1)
  );

  // Reference model state, one slot per configuration
  int   waitc[2] = '{4, 0};
  int   maxc[2]  = '{65535, 3};
  int   left[2]  = '{0, 0};   // stall cycles still owed by the current access
  bit   owed[2]  = '{0, 0};   // a ready cycle is owed after the stalls
  int   scnt[2]  = '{0, 0};
  int   fcnt[2]  = '{0, 0};

  exp_t q0[$];
  exp_t q1[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;

  task automatic model_step(input int k, input bit r, h, b, m, c, output exp_t e);
    bit stall, ready, fl, hz;
    e = '0;
    if (r) begin
      left[k] = 0; owed[k] = 0; scnt[k] = 0; fcnt[k] = 0;
      return;
    end
    stall = 0;
    ready = 0;
    if (owed[k]) begin
      ready   = 1;
      owed[k] = 0;
    end else if (left[k] > 0) begin
      stall = 1;
      left[k]--;
      if (left[k] == 0) owed[k] = 1;
    end else if (m) begin
      if (waitc[k] == 0) ready = 1;
      else begin
        stall   = 1;
        left[k] = waitc[k] - 1;
        if (left[k] == 0) owed[k] = 1;
      end
    end
    fl = !stall && b;
    hz = !stall && !b && h;
    e.ctrl = {stall | hz, stall, stall, stall, fl, fl | hz, stall, ready};
    e.scnt = 16'(scnt[k]);
    e.fcnt = 16'(fcnt[k]);
    if (c) begin
      scnt[k] = 0;
      fcnt[k] = 0;
    end else begin
      if ((stall || hz) && scnt[k] < maxc[k]) scnt[k]++;
      if (fl && fcnt[k] < maxc[k]) fcnt[k]++;
    end
  endtask

  task automatic step(input bit r, h, b, m, c);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; hazard = h; branch_taken = b; mem_req = m; perf_clr = c;
    model_step(0, r, h, b, m, c, e);
    q0.push_back(e);
    model_step(1, r, h, b, m, c, e);
    q1.push_back(e);
  endtask

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, got, exp);
  endtask

  // Monitor: outputs are presented every cycle; sample on the falling edge
  always @(negedge clk) begin
    exp_t e;
    if (q0.size() != 0 && q1.size() != 0) begin
      e = q0.pop_front();
      check("cfg0_ctrl", {8'h0, f_if0, f_id0, f_exe0, f_mem0, fl_ifid0, fl_idexe0, bub0, rdy0},
            {8'h0, e.ctrl});
      check("cfg0_stall_cnt", scnt0, e.scnt);
      check("cfg0_flush_cnt", fcnt0, e.fcnt);
      e = q1.pop_front();
      check("cfg1_ctrl", {8'h0, f_if1, f_id1, f_exe1, f_mem1, fl_ifid1, fl_idexe1, bub1, rdy1},
            {8'h0, e.ctrl});
      check("cfg1_stall_cnt", {14'h0, scnt1}, e.scnt);
      check("cfg1_flush_cnt", {14'h0, fcnt1}, e.fcnt);
      cyc++;
    end
  end

  initial begin
    // args: rst, hazard, branch_taken, mem_req, perf_clr
    step(1, 0, 0, 0, 0);
    step(1, 1, 1, 1, 1);
    // single access, then idle
    step(0, 0, 0, 1, 0);
    repeat (6) step(0, 0, 0, 0, 0);
    // back-to-back accesses
    repeat (10) step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0);
    // hazard with branch, then hazard alone
    step(0, 1, 1, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    // hazard and branch during a memory stall
    repeat (5) step(0, 1, 1, 1, 0);
    step(0, 0, 0, 0, 0);
    // reset in the middle of an access
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    repeat (6) step(0, 0, 0, 0, 0);
    // saturation then clear together with a hazard
    repeat (5) step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 1);
    step(0, 1, 0, 0, 0);
    repeat (2000) begin
      step($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 20,
           $urandom_range(0, 99) < 35, $urandom_range(0, 99) < 3);
    end
    step(0, 0, 0, 0, 0);
    repeat (4) @(negedge clk);
    n_checks++;
    if (q0.size() == 0 && q1.size() == 0) n_pass++;
    else $display("FAIL drain got=%0d expected=0", q0.size() + q1.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
